mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 16-bit pipeline, directly downstream of the EX/MEM register. It consumes the EX/MEM outputs, runs a request/acknowledge transaction against the data memory for loads and stores, and stalls upstream while a transaction is outstanding. It resolves JEQ branches (redirect plus flush) and contains the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles in WAIT before the access is aborted. Legal range 2..255.

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ControlsIn  in  5  from EX/MEM. [4] RegWrite, [3] MemToReg, [2] MemRead, [1] MemWrite, [0] Jeq.
- ResultIn  in  16  ALU result.
- ZeroIn  in  1  ALU zero flag.
- DataIn  in  16  store data.
- MemAddrIn  in  16  data-memory address.
- JEQAddrIn  in  16  branch target.
- Reg1In  in  3  destination register.
- MemReq  out  1  memory request.
- MemWe  out  1  1 = write, 0 = read; valid while MemReq=1.
- MemAddr  out  16  equals MemAddrIn while MemReq=1.
- MemWData  out  16  equals DataIn while MemReq=1.
- MemRData  in  16  read data; sampled only in the MemAck cycle.
- MemAck  in  1  completes the transaction; ignored when MemReq=0.
- Stall  out  1  EX/MEM and all earlier stages hold their contents.
- BranchTaken  out  1  JEQ taken; PC loads BranchTarget.
- BranchTarget  out  16  equals JEQAddrIn.
- FlushOut  out  1  flushes IF/ID, ID/EX and EX/MEM; equals BranchTaken.
- MemErr  out  1  sticky flag: an access timed out.
- WbRegWrite  out  1  MEM/WB RegWrite.
- WbData  out  16  MEM/WB write-back data.
- WbReg  out  3  MEM/WB destination register.

## Operation
- Access = ControlsIn[2] | ControlsIn[1]. If both bits are set, the access is a write (MemWe=1) and the read data is discarded.
- FSM states:
  - IDLE: MemReq = Access.
    - Access & MemAck: zero-wait completion; Stall=0; stay in IDLE.
    - Access & !MemAck: Stall=1; go to WAIT; counter cleared to 0.
    - No access: Stall=0.
  - WAIT: MemReq=1, Stall=1, counter increments every cycle.
    - MemAck: Stall=0 in that cycle; return to IDLE.
    - No MemAck and counter = MEM_TIMEOUT-1: Stall=0 in that cycle; set MemErr; treat read data as 0x0000; return to IDLE.
- The completion cycle is any cycle with Stall=0 while an entry is present.
- Branch: BranchTaken = Jeq & ZeroIn & !Stall. An entry that is both JEQ and a memory access redirects only in its completion cycle.
- MEM/WB register, updated on every edge:
  - Stall=1: captures a bubble (WbRegWrite=0, WbData=0, WbReg=0).
  - Otherwise: WbRegWrite=ControlsIn[4]; WbReg=Reg1In; WbData = MemToReg ? (MemAck ? MemRData : 0x0000) : ResultIn.
- MemErr stays set until Reset.

## Timing
- Reset low (asynchronous):
  - State goes to IDLE; counter=0; MemErr=0; WbRegWrite=0, WbData=0, WbReg=0.
  - MemReq, Stall, BranchTaken and FlushOut are forced to 0 for as long as Reset is low, including in the middle of an access. The aborted access is not retried by this block.
- Latency:
  - Non-memory entry: MEM/WB is valid 1 edge after the entry is presented.
  - Access acknowledged k cycles after MemReq rises (k ≥ 0): Stall is high for k cycles, and MEM/WB is valid at the edge that ends the ack cycle.
- Handshake:
  - MemReq, MemWe, MemAddr and MemWData stay stable from MemReq rise until the ack cycle.
  - MemReq drops in the cycle after the ack unless the next entry is also an access, in which case MemReq stays high back-to-back.
- Timeout: at most MEM_TIMEOUT stall cycles per access.
- Outputs that are combinational from the inputs: Stall, MemReq, BranchTaken, FlushOut.

## Structure
- Shared package: control-bit index constants (CTL_REGWRITE=4, CTL_MEMTOREG=3, CTL_MEMREAD=2, CTL_MEMWRITE=1, CTL_JEQ=0) and the FSM state encoding (IDLE, WAIT). The EX and EX/MEM stages use the same constants.
- One sub-module, mem_wb_reg: the MEM/WB register with bubble-on-stall and asynchronous active-low reset.
- Rest of the logic (FSM, counter, branch logic) lives in mem_stage.

## Test plan
- Load, zero-wait: ControlsIn=5'b11100, MemAddrIn=0x0040, MemAck=1 in the same cycle, MemRData=0xBEEF. Expected: Stall never asserts; next edge gives WbRegWrite=1, WbData=0xBEEF.
- Store, 3-cycle ack: ControlsIn=5'b00010, DataIn=0x1234, ack on the 4th MemReq cycle. Expected: Stall=1 for exactly 3 cycles; MemWe=1 and MemWData=0x1234 stable throughout; MEM/WB holds bubbles, then WbRegWrite=0.
- JEQ: ControlsIn=5'b00001, ZeroIn=1, JEQAddrIn=0x00A0. Expected: BranchTaken=1, FlushOut=1, BranchTarget=0x00A0 in the same cycle. Repeat with ZeroIn=0: expected BranchTaken=0.
- Timeout: load with MemAck held at 0 and MEM_TIMEOUT=16. Expected: Stall=1 for 16 cycles; MemErr=1 from the following edge; WbData=0x0000; MemErr stays set through later traffic.
- Reset mid-WAIT: Reset driven low 2 cycles into an outstanding load. Expected: MemReq, Stall and all Wb* outputs go to 0 immediately, with no clock edge required; after release, state is IDLE and a fresh access completes normally.
- Back-to-back: two loads, each acked after 1 cycle. Expected: MemReq stays continuously high; two valid MEM/WB entries separated by exactly one bubble each.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: control-bit positions used by EX, EX/MEM and MEM,
// plus the memory-access FSM state encoding.
package mem_stage_pkg;

    localparam int unsigned CTL_W        = 5;
    localparam int unsigned CTL_REGWRITE = 4;
    localparam int unsigned CTL_MEMTOREG = 3;
    localparam int unsigned CTL_MEMREAD  = 2;
    localparam int unsigned CTL_MEMWRITE = 1;
    localparam int unsigned CTL_JEQ      = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // An entry touches data memory if it reads or writes.
    function automatic logic is_access(input logic [CTL_W-1:0] ctl);
        return ctl[CTL_MEMREAD] | ctl[CTL_MEMWRITE];
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a bubble whenever the MEM stage is stalled.
module mem_wb_reg #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              reg_write_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [REG_W-1:0]  reg_i,
    output logic              reg_write_o,
    output logic [DATA_W-1:0] data_o,
    output logic [REG_W-1:0]  reg_o
);

    logic              reg_write_q, reg_write_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [REG_W-1:0]  reg_q, reg_d;

    // Select the incoming entry or a bubble
    always_comb begin
        reg_write_d = 1'b0;
        data_d      = '0;
        reg_d       = '0;
        if (!stall_i) begin
            reg_write_d = reg_write_i;
            data_d      = data_i;
            reg_d       = reg_i;
        end
    end

    // Register update with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_write_q <= 1'b0;
            data_q      <= '0;
            reg_q       <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            data_q      <= data_d;
            reg_q       <= reg_d;
        end
    end

    assign reg_write_o = reg_write_q;
    assign data_o      = data_q;
    assign reg_o       = reg_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory req/ack handshake with timeout,
// upstream stall, JEQ branch resolution and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ControlsIn,
    input  logic [15:0] ResultIn,
    input  logic        ZeroIn,
    input  logic [15:0] DataIn,
    input  logic [15:0] MemAddrIn,
    input  logic [15:0] JEQAddrIn,
    input  logic [2:0]  Reg1In,
    output logic        MemReq,
    output logic        MemWe,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    input  logic [15:0] MemRData,
    input  logic        MemAck,
    output logic        Stall,
    output logic        BranchTaken,
    output logic [15:0] BranchTarget,
    output logic        FlushOut,
    output logic        MemErr,
    output logic        WbRegWrite,
    output logic [15:0] WbData,
    output logic [2:0]  WbReg
);

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        access;
    logic        req;
    logic        stall;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] wb_data;

    assign access = is_access(ControlsIn);

    // Handshake FSM: request/stall generation, wait counter and timeout detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                req   = access;
                cnt_d = '0;
                if (access && !MemAck) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (MemAck) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Timeout releases the pipeline; the entry retires with zero read data
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, wait counter and sticky error flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the combinational handshake/branch outputs immediately
    assign MemReq       = req & Reset;
    assign Stall        = stall & Reset;
    assign MemWe        = ControlsIn[CTL_MEMWRITE];
    assign MemAddr      = MemAddrIn;
    assign MemWData     = DataIn;
    assign MemErr       = err_q;

    assign BranchTaken  = Reset & ControlsIn[CTL_JEQ] & ZeroIn & ~stall;
    assign BranchTarget = JEQAddrIn;
    assign FlushOut     = BranchTaken;

    // Read data is only meaningful on an acknowledged read; writes discard it
    assign ack     = MemAck & MemReq;
    assign rdata   = (ack && !MemWe) ? MemRData : '0;
    assign wb_data = ControlsIn[CTL_MEMTOREG] ? rdata : ResultIn;

    mem_wb_reg #(
        .DATA_W(16),
        .REG_W (3)
    ) u_mem_wb (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .stall_i    (Stall),
        .reg_write_i(ControlsIn[CTL_REGWRITE]),
        .data_i     (wb_data),
        .reg_i      (Reg1In),
        .reg_write_o(WbRegWrite),
        .data_o     (WbData),
        .reg_o      (WbReg)
    );

endmodule
